// File: rtl/axis_pkg.sv
// Shared definitions for the stream-to-AXI write packer: FSM encoding,
// width-ratio helpers and the beat buffer entry layout {end, last, strb, data}.
package axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACTIVE
  } state_t;

  function automatic int ratio_of(input int axi_dw, input int dw);
    return axi_dw / dw;
  endfunction

  // Lane index needs at least one bit even when RATIO is 1.
  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int strb_lsb(input int axi_dw);
    return axi_dw;
  endfunction

  function automatic int last_bit(input int axi_dw);
    return axi_dw + axi_dw / 8;
  endfunction

  function automatic int end_bit(input int axi_dw);
    return axi_dw + axi_dw / 8 + 1;
  endfunction

  function automatic int entry_width(input int axi_dw);
    return axi_dw + axi_dw / 8 + 2;
  endfunction

endpackage

// File: rtl/axis_write_pack_if.sv
// Command, input-stream and AXI W channel bundle for axis_write_pack.
// master: the packer (drives the W channel); slave: the surrounding system.
interface axis_write_pack_if #(
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
);
  logic [CFG_DWIDTH-1:0]       cfg_length;
  logic                        cfg_val;
  logic                        cfg_rdy;
  logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic                        axi_wlast;
  logic                        axi_wvalid;
  logic                        axi_wready;
  logic [DATA_WIDTH-1:0]       data;
  logic                        valid;
  logic                        ready;
  logic                        done;

  modport master (
    input  cfg_length, cfg_val, axi_wready, data, valid,
    output cfg_rdy, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, ready, done
  );

  modport slave (
    output cfg_length, cfg_val, axi_wready, data, valid,
    input  cfg_rdy, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, ready, done
  );
endinterface

// File: rtl/axis_fifo.sv
// Show-ahead synchronous FIFO with a registered almost-full flag that already
// reflects the push/pop happening at the current edge.
module axis_fifo #(
  parameter int WIDTH     = 8,
  parameter int AWIDTH    = 2,
  parameter int AF_MARGIN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             afull
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [AWIDTH:0]   cnt, cnt_nxt;
  logic              wr_en, rd_en;

  assign empty = (cnt == '0);
  assign rd_en = rd && !empty;
  // A push into a full FIFO is accepted when a pop frees the slot at the same edge.
  assign wr_en = wr && ((cnt != (AWIDTH+1)'(DEPTH)) || rd_en);
  assign dout  = mem[rd_ptr];

  // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
  always_comb begin
    cnt_nxt = cnt;
    if (wr_en && !rd_en)      cnt_nxt = cnt + (AWIDTH+1)'(1);
    else if (rd_en && !wr_en) cnt_nxt = cnt - (AWIDTH+1)'(1);
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      afull  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AWIDTH'(1);
      if (rd_en) rd_ptr <= rd_ptr + AWIDTH'(1);
      cnt   <= cnt_nxt;
      afull <= (cnt_nxt >= (AWIDTH+1)'(DEPTH - AF_MARGIN));
    end
  end

  // NOTE: storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axis_write_pack.sv
// Packs a narrow word stream into wide AXI W beats with strobes for a partial
// final beat, wlast every 2^AXI_LEN_WIDTH beats, and a done pulse per transfer.
module axis_write_pack
  import axis_pkg::*;
#(
  parameter int BUF_AWIDTH     = 4,
  parameter int CMD_AWIDTH     = 2,
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_LEN_WIDTH  = 4,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
) (
  input logic                clk,
  input logic                rst_n,
  axis_write_pack_if.master  bus
);
  localparam int RATIO     = ratio_of(AXI_DATA_WIDTH, DATA_WIDTH);
  localparam int IDX_W     = idx_width(RATIO);
  localparam int STRB_W    = AXI_DATA_WIDTH / 8;
  localparam int LANE_STRB = DATA_WIDTH / 8;
  localparam int ENT_W     = entry_width(AXI_DATA_WIDTH);
  localparam int STRB_LSB  = strb_lsb(AXI_DATA_WIDTH);
  localparam int LAST_BIT  = last_bit(AXI_DATA_WIDTH);
  localparam int END_BIT   = end_bit(AXI_DATA_WIDTH);

  state_t                    state;
  logic [CFG_DWIDTH-1:0]     len_q, words;
  logic [IDX_W-1:0]          idx;
  logic [AXI_LEN_WIDTH-1:0]  beat_cnt;
  logic [AXI_DATA_WIDTH-1:0] lane_data, beat_data;
  logic [STRB_W-1:0]         beat_strb;
  logic                      run_q;

  logic                      cmd_rd, cmd_empty, cmd_afull;
  logic [CFG_DWIDTH-1:0]     cmd_dout;
  logic                      buf_empty, buf_afull, push, pop;
  logic [ENT_W-1:0]          buf_din, buf_dout;
  logic                      accept, final_word, lane_full;

  assign cmd_rd     = (state == ST_IDLE) && !cmd_empty;
  assign bus.ready  = (state == ST_ACTIVE) && !buf_afull;
  assign accept     = bus.valid && bus.ready;
  assign final_word = (words == CFG_DWIDTH'(1));
  assign lane_full  = (idx == IDX_W'(RATIO - 1));
  assign push       = accept && (lane_full || final_word);

  axis_fifo #(.WIDTH(CFG_DWIDTH), .AWIDTH(CMD_AWIDTH)) u_cmd_q (
    .clk(clk), .rst_n(rst_n),
    .wr(bus.cfg_val && bus.cfg_rdy), .din(bus.cfg_length),
    .rd(cmd_rd), .dout(cmd_dout), .empty(cmd_empty), .afull(cmd_afull)
  );

  // The completing word is merged straight into the beat so it is pushed at its own accept edge.
  always_comb begin
    beat_data = lane_data;
    beat_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH] = bus.data;
    for (int i = 0; i < RATIO; i++) begin
      beat_strb[i*LANE_STRB +: LANE_STRB] = (i <= int'(idx)) ? '1 : '0;
    end
  end

  assign buf_din = {final_word, final_word || (&beat_cnt), beat_strb, beat_data};

  axis_fifo #(.WIDTH(ENT_W), .AWIDTH(BUF_AWIDTH)) u_beat_buf (
    .clk(clk), .rst_n(rst_n),
    .wr(push), .din(buf_din),
    .rd(pop), .dout(buf_dout), .empty(buf_empty), .afull(buf_afull)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      words     <= '0;
      idx       <= '0;
      beat_cnt  <= '0;
      lane_data <= '0;
      run_q     <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!cmd_empty) begin
            len_q <= cmd_dout;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          words     <= len_q;
          idx       <= '0;
          beat_cnt  <= '0;
          lane_data <= '0;
          state     <= (len_q == '0) ? ST_IDLE : ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (accept) begin
            words <= words - CFG_DWIDTH'(1);
            if (push) begin
              idx       <= '0;
              lane_data <= '0;
              beat_cnt  <= beat_cnt + AXI_LEN_WIDTH'(1);
            end else begin
              idx <= idx + IDX_W'(1);
              lane_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= bus.data;
            end
            if (final_word) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Payload is masked while no beat is presented so the bus reads zero when idle or in reset.
  assign bus.axi_wvalid = !buf_empty;
  assign pop            = bus.axi_wvalid && bus.axi_wready;
  assign bus.axi_wdata  = bus.axi_wvalid ? buf_dout[AXI_DATA_WIDTH-1:0] : '0;
  assign bus.axi_wstrb  = bus.axi_wvalid ? buf_dout[STRB_LSB +: STRB_W] : '0;
  assign bus.axi_wlast  = bus.axi_wvalid && buf_dout[LAST_BIT];
  assign bus.done       = pop && buf_dout[END_BIT];
  assign bus.cfg_rdy    = run_q && !cmd_afull;

endmodule

// File: tb/tb_axis_write_pack.sv
// Scoreboard bench for axis_write_pack: a 64-bit (RATIO 2) and a 32-bit (RATIO 1) instance,
// expected beats derived from the packing rules and compared by an independent monitor.
module tb_axis_write_pack;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        fin;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        cfg_val, valid, wready;
  logic [31:0] cfg_length, data;
  logic        data_en, gaps;
  int          wr_mode;

  int n_checks = 0, n_fail = 0;
  int n_acc = 0, n_beats = 0, n_last = 0, n_done = 0;

  beat_t       exp_q[$];
  logic [31:0] word_q[$];

  always #5 clk = ~clk;

  axis_write_pack_if #(.AXI_DATA_WIDTH(64)) bus_a ();
  axis_write_pack_if #(.AXI_DATA_WIDTH(32)) bus_b ();

  axis_write_pack #(.AXI_DATA_WIDTH(64)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  axis_write_pack #(.AXI_DATA_WIDTH(32)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  assign bus_a.cfg_val    = cfg_val && !sel;
  assign bus_b.cfg_val    = cfg_val && sel;
  assign bus_a.cfg_length = cfg_length;
  assign bus_b.cfg_length = cfg_length;
  assign bus_a.valid      = valid && !sel;
  assign bus_b.valid      = valid && sel;
  assign bus_a.data       = data;
  assign bus_b.data       = data;
  assign bus_a.axi_wready = wready;
  assign bus_b.axi_wready = wready;

  wire [63:0] o_wdata  = sel ? {32'h0, bus_b.axi_wdata} : bus_a.axi_wdata;
  wire [7:0]  o_wstrb  = sel ? {4'h0, bus_b.axi_wstrb} : bus_a.axi_wstrb;
  wire        o_wlast  = sel ? bus_b.axi_wlast  : bus_a.axi_wlast;
  wire        o_wvalid = sel ? bus_b.axi_wvalid : bus_a.axi_wvalid;
  wire        o_done   = sel ? bus_b.done       : bus_a.done;
  wire        o_ready  = sel ? bus_b.ready      : bus_a.ready;
  wire        o_cfg_rdy = sel ? bus_b.cfg_rdy   : bus_a.cfg_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: word i of the transfer lands in beat i/R, lane i%R; wlast every 16th beat and on the final one.
  task automatic model_cmd(input int len, input bit inc);
    int          r  = sel ? 1 : 2;
    int          nb = (len + r - 1) / r;
    logic [31:0] w[$];
    beat_t       b;
    for (int i = 0; i < len; i++) begin
      w.push_back(inc ? 32'(i + 1) : $urandom());
      word_q.push_back(w[i]);
    end
    for (int k = 0; k < nb; k++) begin
      b = '0;
      for (int l = 0; l < r; l++) begin
        if (k * r + l < len) begin
          b.data |= 64'(w[k*r+l]) << (32 * l);
          b.strb |= 8'(8'hF << (4 * l));
        end
      end
      b.last = ((k + 1) % 16 == 0) || (k == nb - 1);
      b.fin  = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_cmd(input int len, input bit inc);
    int c = 0;
    @(negedge clk);
    cfg_length = 32'(len);
    cfg_val    = 1'b1;
    #1;
    while (!o_cfg_rdy && c < 500) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (!o_cfg_rdy) begin
      fail_now("cmd_accept_timeout");
      cfg_val = 1'b0;
      return;
    end
    model_cmd(len, inc);
    @(posedge clk);
    #1 cfg_val = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int c = 0;
    while ((exp_q.size() != 0 || word_q.size() != 0) && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    if (c >= max_cycles) fail_now("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_stats();
    n_beats = 0;
    n_last  = 0;
    n_done  = 0;
  endtask

  task automatic run_one(input int len, input int beats, input int lasts);
    clear_stats();
    send_cmd(len, 1'b1);
    wait_drain(10000);
    check("beat_count", 64'(n_beats), 64'(beats));
    check("wlast_count", 64'(n_last), 64'(lasts));
    check("done_count", 64'(n_done), 64'd1);
  endtask

  // Input word driver: presents queued words, accepted when ready is high at the edge.
  initial begin
    logic fire;
    forever begin
      @(negedge clk);
      if (rst_n && data_en && word_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        valid = 1'b1;
        data  = word_q[0];
      end else begin
        valid = 1'b0;
      end
      #1 fire = valid && o_ready;
      @(posedge clk);
      if (fire && word_q.size() != 0) begin
        void'(word_q.pop_front());
        n_acc++;
      end
    end
  end

  // W channel monitor: drives wready and scores every handshake against the queue.
  initial begin
    beat_t e;
    logic  hs;
    forever begin
      @(negedge clk);
      case (wr_mode)
        0:       wready = 1'b1;
        1:       wready = 1'b0;
        2:       wready = ~wready;
        default: wready = 1'($urandom_range(0, 1));
      endcase
      #1;
      hs = o_wvalid && wready;
      if (rst_n && o_done && !hs) fail_now("done_without_handshake");
      if (rst_n && hs) begin
        n_beats++;
        if (o_wlast) n_last++;
        if (o_done) n_done++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          e = exp_q.pop_front();
          check("wdata", o_wdata, e.data);
          check("wstrb", 64'(o_wstrb), 64'(e.strb));
          check("wlast", 64'(o_wlast), 64'(e.last));
          check("done", 64'(o_done), 64'(e.fin));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    cfg_val = 1'b0; cfg_length = '0; valid = 1'b0; data = '0; wready = 1'b0;
    sel = 1'b0; wr_mode = 0; data_en = 1'b1; gaps = 1'b0; rst_n = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_a_ctrl", 64'({bus_a.cfg_rdy, bus_a.ready, bus_a.axi_wvalid, bus_a.axi_wlast, bus_a.done}), 64'd0);
    check("rst_a_wdata", bus_a.axi_wdata, 64'd0);
    check("rst_a_wstrb", 64'(bus_a.axi_wstrb), 64'd0);
    check("rst_b_ctrl", 64'({bus_b.cfg_rdy, bus_b.ready, bus_b.axi_wvalid, bus_b.axi_wlast, bus_b.done}), 64'd0);
    check("rst_b_data_strb", 64'({bus_b.axi_wstrb, bus_b.axi_wdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("cfg_rdy_before_edge", 64'(o_cfg_rdy), 64'd0);
    @(negedge clk);
    #1 check("cfg_rdy_after_edge", 64'(o_cfg_rdy), 64'd1);

    // Full beats, partial final beat, long multi-burst transfer.
    run_one(8, 4, 1);
    run_one(5, 3, 1);
    run_one(4092, 2046, 128);

    // Back-pressure: 16-entry buffer holds 32 words, then alternating wready drains it.
    clear_stats();
    wr_mode = 1;
    base = n_acc;
    send_cmd(64, 1'b0);
    repeat (60) @(negedge clk);
    #1;
    check("words_before_stall", 64'(n_acc - base), 64'd32);
    check("ready_low_when_full", 64'(o_ready), 64'd0);
    check("wvalid_held", 64'(o_wvalid), 64'd1);
    wr_mode = 2;
    wait_drain(2000);
    check("bp_beat_count", 64'(n_beats), 64'd32);
    check("bp_done_count", 64'(n_done), 64'd1);

    // Command queue fill with a zero-length command in the middle.
    clear_stats();
    wr_mode = 0;
    data_en = 1'b0;
    send_cmd(3, 1'b0);
    send_cmd(0, 1'b0);
    send_cmd(2, 1'b0);
    send_cmd(4, 1'b0);
    send_cmd(1, 1'b0);
    @(negedge clk);
    #1 check("cfg_rdy_low_when_full", 64'(o_cfg_rdy), 64'd0);
    data_en = 1'b1;
    wait_drain(2000);
    check("q_done_count", 64'(n_done), 64'd4);
    check("q_beat_count", 64'(n_beats), 64'd6);

    // Reset in the middle of an active transfer.
    wr_mode = 1;
    send_cmd(16, 1'b1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    word_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    check("midrst_ctrl", 64'({o_cfg_rdy, o_ready, o_wvalid, o_wlast, o_done}), 64'd0);
    check("midrst_wdata", o_wdata, 64'd0);
    check("midrst_wstrb", 64'(o_wstrb), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_mode = 0;
    repeat (2) @(negedge clk);
    run_one(2, 1, 1);

    // RATIO = 1 instance.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    run_one(8, 8, 1);
    run_one(5, 5, 1);

    // Randomised traffic on both widths.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      wr_mode = 3;
      gaps = 1'b1;
      clear_stats();
      for (int k = 0; k < 6; k++) send_cmd($urandom_range(1, 40), 1'b0);
      wait_drain(5000);
      check("rand_done_count", 64'(n_done), 64'd6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
